fetch_stage: RTL and testbench

//  Instruction-fetch stage upstream of the instruction memory (IM) in the LEGv8 datapath.
//  - Owns the program counter and drives busPc to IM.
//  - IM returns `instruction` combinationally in the same cycle.
//  - Captures instruction+PC into an IF/ID register with valid/ready handshake to decode.
//  - Handles branch redirect/flush, halt-on-zero-word and address faults.

---
 rtl/legv8_pkg.sv | 16 +
 rtl/fetch_fsm.sv | 72 +++++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath types and constants.
package legv8_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  // An all-zero instruction word stops fetch.
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch control: RUN/HALT/FAULT state register plus the per-cycle decode of
// redirect, capture and fault entry for the fetch datapath.
module fetch_fsm
  import legv8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ifid_valid,
  input  logic         i_id_ready,
  input  logic         i_redirect_valid,
  input  logic         i_redirect_aligned,
  input  logic         i_pc_in_range,
  input  logic         i_halt_word,
  output fetch_state_t o_state,
  output logic         o_redirect,
  output logic         o_capture,
  output logic         o_fault_entry,
  output logic         o_fault_on_redirect
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic         w_slot_free;

  // IF/ID can take a new word when empty or being drained this cycle.
  assign w_slot_free = !i_ifid_valid || i_id_ready;
  assign o_state     = r_state;

  // State register; FAULT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; redirect outranks fetch outside FAULT.
  always_comb begin
    w_state_nxt         = r_state;
    o_redirect          = 1'b0;
    o_capture           = 1'b0;
    o_fault_entry       = 1'b0;
    o_fault_on_redirect = 1'b0;
    case (r_state)
      RUN, HALT: begin
        if (i_redirect_valid) begin
          o_redirect = 1'b1;
          if (i_redirect_aligned) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt         = FAULT;
            o_fault_entry       = 1'b1;
            o_fault_on_redirect = 1'b1;
          end
        end else if ((r_state == RUN) && w_slot_free) begin
          if (!i_pc_in_range) begin
            w_state_nxt   = FAULT;
            o_fault_entry = 1'b1;
          end else if (i_halt_word) begin
            w_state_nxt = HALT;
          end else begin
            o_capture = 1'b1;
          end
        end
      end
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = RUN;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, presents it to the instruction
// memory, and captures the returned word into the IF/ID register.
module fetch_stage #(
  parameter int unsigned     PC_W       = 64,
  parameter int unsigned     INSTR_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     IM_ADDR_HI = 10,
  parameter int unsigned     CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    busPc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               id_ready,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic               fault,
  output logic [PC_W-1:0]    fault_pc,
  output logic [CNT_W-1:0]   fetch_count
);

  import legv8_pkg::*;

  logic [PC_W-1:0]    r_pc;
  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc;
  logic [PC_W-1:0]    r_fault_pc;
  logic [CNT_W-1:0]   r_fetch_count;

  fetch_state_t w_state;
  logic         w_in_range;
  logic         w_halt_word;
  logic         w_redirect;
  logic         w_capture;
  logic         w_fault_entry;
  logic         w_fault_on_redirect;

  // PC bits above the IM decode window must be zero.
  assign w_in_range  = (r_pc >> (IM_ADDR_HI + 1)) == '0;
  assign w_halt_word = instruction == INSTR_W'(HALT_WORD);

  fetch_fsm u_fetch_fsm (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_ifid_valid        (r_ifid_valid),
    .i_id_ready          (id_ready),
    .i_redirect_valid    (redirect_valid),
    .i_redirect_aligned  (redirect_pc[1:0] == 2'b00),
    .i_pc_in_range       (w_in_range),
    .i_halt_word         (w_halt_word),
    .o_state             (w_state),
    .o_redirect          (w_redirect),
    .o_capture           (w_capture),
    .o_fault_entry       (w_fault_entry),
    .o_fault_on_redirect (w_fault_on_redirect)
  );

  // Program counter: aligned redirect loads the target, capture advances by one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect && !w_fault_on_redirect) begin
      r_pc <= redirect_pc;
    end else if (w_capture) begin
      r_pc <= r_pc + PC_W'(4);
    end
  end

  // IF/ID valid: flushed by redirect or FAULT, set on capture, drained by id_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
    end else if ((w_state == FAULT) || w_redirect) begin
      r_ifid_valid <= 1'b0;
    end else if (w_capture) begin
      r_ifid_valid <= 1'b1;
    end else if (id_ready) begin
      r_ifid_valid <= 1'b0;
    end
  end

  // IF/ID payload and the saturating count of accepted instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_instr  <= '0;
      r_ifid_pc     <= '0;
      r_fetch_count <= '0;
    end else if (w_capture) begin
      r_ifid_instr <= instruction;
      r_ifid_pc    <= r_pc;
      if (r_fetch_count != '1) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end
    end
  end

  // Offending address, latched once on the way into FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_pc <= '0;
    end else if (w_fault_on_redirect) begin
      r_fault_pc <= redirect_pc;
    end else if (w_fault_entry) begin
      r_fault_pc <= r_pc;
    end
  end

  assign busPc       = r_pc;
  assign ifid_valid  = r_ifid_valid;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_pc     = r_ifid_pc;
  assign halted      = (w_state == HALT);
  assign fault       = (w_state == FAULT);
  assign fault_pc    = r_fault_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus
// randomized runs, all checked every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] busPc;
  logic [31:0] instruction;
  logic        id_ready = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        halted;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_W       (64),
    .INSTR_W    (32),
    .RESET_PC   (64'h0),
    .IM_ADDR_HI (10),
    .CNT_W      (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .busPc          (busPc),
    .instruction    (instruction),
    .id_ready       (id_ready),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  // Instruction memory: 512 words, combinational read.
  logic [31:0] mem [512];
  assign instruction = mem[busPc[10:2]];

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model of the visible fetch state.
  localparam int MRun = 0, MHalt = 1, MFault = 2;
  int          m_st;
  logic [63:0] m_pc, m_ipc, m_fpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = MRun; m_pc = 64'h0; m_ipc = '0; m_fpc = '0;
    m_instr = '0; m_cnt = '0; m_valid = 1'b0;
  endtask

  // One clock edge worth of fetch behaviour, from the rules for each state.
  task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rpc);
    logic [31:0] word;
    word = mem[m_pc[10:2]];
    if (m_st == MFault) begin
      m_valid = 1'b0;
    end else if (rv) begin
      m_valid = 1'b0;
      if (rpc % 4 == 0) begin
        m_pc = rpc; m_st = MRun;
      end else begin
        m_fpc = rpc; m_st = MFault;
      end
    end else if (m_st == MHalt) begin
      if (rdy) m_valid = 1'b0;
    end else if (m_valid && !rdy) begin
      // decode stalled: nothing moves
    end else if (m_pc >= 64'h800) begin
      m_fpc = m_pc; m_st = MFault; m_valid = 1'b0;
    end else if (word == 32'h0) begin
      m_st = MHalt;
      if (rdy) m_valid = 1'b0;
    end else begin
      m_instr = word; m_ipc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Every cycle: all outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("busPc", busPc, m_pc);
    chk("ifid_valid", ifid_valid, m_valid);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("halted", halted, m_st == MHalt);
    chk("fault", fault, m_st == MFault);
    chk("fault_pc", fault_pc, m_fpc);
    chk("fetch_count", fetch_count, m_cnt);
  end

  // Starts and ends just after a falling edge; spans one rising edge.
  task automatic cyc(input logic rdy, input logic rv, input logic [63:0] rpc);
    id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    model_step(rdy, rv, rpc);
    @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 512; i++) mem[i] = 32'h9100_0000 | i;
    mem[0] = 32'hF840_02A0; mem[1] = 32'hF840_02A1;
    mem[2] = 32'h8B00_0023; mem[3] = 32'hF800_02A3;
    mem[4] = 32'h0;
  endtask

  initial begin
    logic [63:0] rpc;
    int          r;
    load_program();
    model_reset();
    @(negedge clk); #1;

    // Straight-line fetch, then halt on the zero word, then redirect out of HALT.
    do_reset();
    chk("rst busPc", busPc, 64'h0);
    chk("rst valid", ifid_valid, 1'b0);
    cyc(1, 0, 0); chk("t1 pc0", ifid_pc, 64'h0); chk("t1 ins0", ifid_instr, 32'hF840_02A0);
    cyc(1, 0, 0); chk("t1 pc4", ifid_pc, 64'h4); chk("t1 ins1", ifid_instr, 32'hF840_02A1);
    cyc(1, 0, 0); chk("t1 pc8", ifid_pc, 64'h8); chk("t1 ins2", ifid_instr, 32'h8B00_0023);
    cyc(1, 0, 0); chk("t1 pcC", ifid_pc, 64'hC); chk("t1 ins3", ifid_instr, 32'hF800_02A3);
    chk("t1 count", fetch_count, 32'd4);
    cyc(1, 0, 0); chk("t4 halted", halted, 1'b1); chk("t4 busPc", busPc, 64'h10);
    chk("t4 valid", ifid_valid, 1'b0);
    cyc(1, 1, 64'h4); chk("t4 unhalt", halted, 1'b0); chk("t4 bubble", ifid_valid, 1'b0);
    chk("t4 busPc4", busPc, 64'h4);
    cyc(1, 0, 0); chk("t4 resume", ifid_pc, 64'h4); chk("t4 resv", ifid_valid, 1'b1);

    // Stall, resume, redirect during stall, then misaligned redirect fault.
    do_reset();
    cyc(1, 0, 0); cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk("t2 busPc", busPc, 64'h8); chk("t2 ifid_pc", ifid_pc, 64'h4);
      chk("t2 count", fetch_count, 32'd2);
    end
    cyc(1, 0, 0); chk("t2 resume", ifid_pc, 64'h8);
    cyc(0, 1, 64'h0); chk("t3 flush", ifid_valid, 1'b0); chk("t3 busPc", busPc, 64'h0);
    cyc(1, 0, 0); chk("t3 pc", ifid_pc, 64'h0); chk("t3 ins", ifid_instr, 32'hF840_02A0);
    cyc(1, 1, 64'h6); chk("t5 fault", fault, 1'b1); chk("t5 fpc", fault_pc, 64'h6);
    chk("t5 busPc", busPc, 64'h4);
    cyc(1, 1, 64'h0); chk("t5 sticky", fault, 1'b1); chk("t5 ignored", busPc, 64'h4);

    // Out-of-range redirect target faults when fetch reaches it.
    do_reset();
    cyc(1, 1, 64'h800); chk("t6 nofault", fault, 1'b0); chk("t6 busPc", busPc, 64'h800);
    cyc(1, 0, 0); chk("t6 fault", fault, 1'b1); chk("t6 fpc", fault_pc, 64'h800);
    chk("t6 nocap", ifid_valid, 1'b0); chk("t6 count", fetch_count, 32'd0);

    // Asynchronous reset in the middle of the high phase.
    do_reset();
    cyc(1, 0, 0); cyc(1, 0, 0);
    id_ready = 1'b1; model_step(1, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0; model_reset(); #1;
    chk("t7 busPc", busPc, 64'h0); chk("t7 valid", ifid_valid, 1'b0);
    chk("t7 ifid_pc", ifid_pc, 64'h0); chk("t7 count", fetch_count, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Randomized runs over random memory images.
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 512; i++)
        mem[i] = ($urandom_range(0, 31) == 0) ? 32'h0 : ($urandom | 32'h1);
      do_reset();
      for (int c = 0; c < 400; c++) begin
        rpc = '0;
        r = $urandom_range(0, 99);
        if ($urandom_range(0, 99) < 8) begin
          if (r < 3)       rpc = {52'h0, 9'($urandom_range(0, 511)), 2'b10, 1'b0} | 64'h1;
          else if (r < 6)  rpc = (r == 4) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h800;
          else if (r < 16) rpc = 64'h7FC;
          else             rpc = {53'h0, 9'($urandom_range(0, 511)), 2'b00};
          cyc(1'($urandom_range(0, 1)), 1'b1, rpc);
        end else begin
          cyc($urandom_range(0, 3) != 0, 1'b0, 64'h0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
